// File: rtl/saturating_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : saturating_accumulator
// Description : Streaming accumulator whose running sum is clamped to a
//               runtime window [min_i, max_i], with valid/ready handshake,
//               a one-entry registered output stage and saturation statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module saturating_accumulator #(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b0,
    parameter int CNT_W  = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    input  logic [W-1:0]     in_data_i,
    output logic             in_ready_o,
    input  logic             clr_i,
    input  logic [W-1:0]     min_i,
    input  logic [W-1:0]     max_i,
    output logic             out_valid_o,
    output logic [W-1:0]     out_data_o,
    output logic             out_sat_o,
    input  logic             out_ready_i,
    output logic [CNT_W-1:0] sat_count_o,
    output logic             sticky_sat_o,
    input  logic             sticky_clr_i
);

    logic [W-1:0]     acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic [CNT_W-1:0] sat_count_q, sat_count_d;
    logic             sticky_q, sticky_d;

    logic             accept;
    logic [W-1:0]     base;
    logic [W:0]       base_x;
    logic [W:0]       sample_x;
    logic [W:0]       min_x;
    logic [W:0]       max_x;
    logic [W:0]       sum_x;
    logic             above_max;
    logic             below_min;
    logic [W-1:0]     result;
    logic             sat;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign base       = clr_i ? '0 : acc_q;

    // One extra bit keeps the sum exact, so neither wrap nor overflow can occur.
    generate
        if (SIGNED) begin : g_signed
            assign base_x    = {base[W-1], base};
            assign sample_x  = {in_data_i[W-1], in_data_i};
            assign min_x     = {min_i[W-1], min_i};
            assign max_x     = {max_i[W-1], max_i};
            assign above_max = $signed(sum_x) > $signed(max_x);
            assign below_min = $signed(sum_x) < $signed(min_x);
        end else begin : g_unsigned
            assign base_x    = {1'b0, base};
            assign sample_x  = {1'b0, in_data_i};
            assign min_x     = {1'b0, min_i};
            assign max_x     = {1'b0, max_i};
            assign above_max = sum_x > max_x;
            assign below_min = sum_x < min_x;
        end
    endgenerate

    assign sum_x = base_x + sample_x;

    // Max test first so an inverted window (min > max) still has one answer.
    always_comb begin
        result = sum_x[W-1:0];
        sat    = 1'b0;
        if (above_max) begin
            result = max_i;
            sat    = 1'b1;
        end else if (below_min) begin
            result = min_i;
            sat    = 1'b1;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        sat_count_d = sat_count_q;
        sticky_d    = sticky_q;

        if (accept) begin
            acc_d       = result;
            out_valid_d = 1'b1;
            out_data_d  = result;
            out_sat_d   = sat;
        end else begin
            if (clr_i) begin
                acc_d = '0;
            end
            if (out_valid_q && out_ready_i) begin
                out_valid_d = 1'b0;
            end
        end

        if (accept && sat && (sat_count_q != {CNT_W{1'b1}})) begin
            sat_count_d = sat_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end

        if (accept && sat) begin
            sticky_d = 1'b1;
        end else if (sticky_clr_i) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            sat_count_q <= '0;
            sticky_q    <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            sat_count_q <= sat_count_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign out_sat_o    = out_sat_q;
    assign sat_count_o  = sat_count_q;
    assign sticky_sat_o = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_saturating_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_saturating_accumulator
// Description : Drives an unsigned (CNT_W=2) and a signed (CNT_W=8) instance
//               with shared stimulus and checks both against integer models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_saturating_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       clr = 1'b0;
    logic [7:0] mn = 8'd0;
    logic [7:0] mx = 8'd0;
    logic       out_ready = 1'b1;
    logic       sticky_clr = 1'b0;

    logic       u_in_ready, u_out_valid, u_out_sat, u_sticky;
    logic [7:0] u_out_data;
    logic [1:0] u_cnt;
    logic       s_in_ready, s_out_valid, s_out_sat, s_sticky;
    logic [7:0] s_out_data;
    logic [7:0] s_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: index 0 = unsigned instance, 1 = signed instance.
    logic [7:0] m_acc[2];
    logic [7:0] m_data[2];
    bit         m_valid[2];
    bit         m_sat[2];
    bit         m_sticky[2];
    int         m_cnt[2];

    always #5 clk = ~clk;

    saturating_accumulator #(.W(8), .SIGNED(1'b0), .CNT_W(2)) u_dut_u (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(u_in_ready), .clr_i(clr), .min_i(mn), .max_i(mx),
        .out_valid_o(u_out_valid), .out_data_o(u_out_data), .out_sat_o(u_out_sat),
        .out_ready_i(out_ready), .sat_count_o(u_cnt), .sticky_sat_o(u_sticky),
        .sticky_clr_i(sticky_clr)
    );

    saturating_accumulator #(.W(8), .SIGNED(1'b1), .CNT_W(8)) u_dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
        .in_ready_o(s_in_ready), .clr_i(clr), .min_i(mn), .max_i(mx),
        .out_valid_o(s_out_valid), .out_data_o(s_out_data), .out_sat_o(s_out_sat),
        .out_ready_i(out_ready), .sat_count_o(s_cnt), .sticky_sat_o(s_sticky),
        .sticky_clr_i(sticky_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_int(input bit sgn, input logic [7:0] v);
        return sgn ? int'($signed(v)) : int'(v);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 8'd0; m_data[k] = 8'd0; m_valid[k] = 1'b0;
            m_sat[k] = 1'b0; m_sticky[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    // Behavioural update for one clock edge, from the inputs presented to it.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit sgn;
            bit take;
            bit sat;
            int sum;
            int lo;
            int hi;
            logic [7:0] res;
            sgn  = (k == 1);
            take = in_valid && (!m_valid[k] || out_ready);
            sat  = 1'b0;
            if (take) begin
                sum = (clr ? 0 : to_int(sgn, m_acc[k])) + to_int(sgn, in_data);
                lo  = to_int(sgn, mn);
                hi  = to_int(sgn, mx);
                if (sum > hi) begin res = mx; sat = 1'b1; end
                else if (sum < lo) begin res = mn; sat = 1'b1; end
                else res = 8'(sum);
                m_acc[k]   = res;
                m_data[k]  = res;
                m_sat[k]   = sat;
                m_valid[k] = 1'b1;
                if (sat && m_cnt[k] < ((k == 0) ? 3 : 255)) m_cnt[k]++;
            end else begin
                if (clr) m_acc[k] = 8'd0;
                if (m_valid[k] && out_ready) m_valid[k] = 1'b0;
            end
            if (take && sat) m_sticky[k] = 1'b1;
            else if (sticky_clr) m_sticky[k] = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_u_vld"}, 32'(u_out_valid), 32'(m_valid[0]));
        chk({tag, "_u_dat"}, 32'(u_out_data),  32'(m_data[0]));
        chk({tag, "_u_sat"}, 32'(u_out_sat),   32'(m_sat[0]));
        chk({tag, "_u_cnt"}, 32'(u_cnt),       32'(m_cnt[0]));
        chk({tag, "_u_stk"}, 32'(u_sticky),    32'(m_sticky[0]));
        chk({tag, "_s_vld"}, 32'(s_out_valid), 32'(m_valid[1]));
        chk({tag, "_s_dat"}, 32'(s_out_data),  32'(m_data[1]));
        chk({tag, "_s_sat"}, 32'(s_out_sat),   32'(m_sat[1]));
        chk({tag, "_s_cnt"}, 32'(s_cnt),       32'(m_cnt[1]));
        chk({tag, "_s_stk"}, 32'(s_sticky),    32'(m_sticky[1]));
    endtask

    // One cycle: drive at negedge, check ready combinationally, then outputs after the edge.
    task automatic step(input string tag, input logic v, input logic [7:0] d, input logic c,
                        input logic [7:0] lo, input logic [7:0] hi, input logic ordy,
                        input logic sclr);
        @(negedge clk);
        in_valid = v; in_data = d; clr = c; mn = lo; mx = hi;
        out_ready = ordy; sticky_clr = sclr;
        #1;
        chk({tag, "_u_rdy"}, 32'(u_in_ready), 32'(!m_valid[0] || ordy));
        chk({tag, "_s_rdy"}, 32'(s_in_ready), 32'(!m_valid[1] || ordy));
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_u_vld", 32'(u_out_valid), 32'd0);
        chk("rst_u_dat", 32'(u_out_data), 32'd0);
        chk("rst_s_cnt", 32'(s_cnt), 32'd0);
        chk("rst_s_stk", 32'(s_sticky), 32'd0);

        // Unsigned window [0,5]: 1, 2, 4 -> 1, 3, 5 (last clamps).
        step("tp1a", 1'b1, 8'd1, 1'b0, 8'd0, 8'd5, 1'b1, 1'b0);
        chk("tp1a_dat", 32'(u_out_data), 32'd1);
        step("tp1b", 1'b1, 8'd2, 1'b0, 8'd0, 8'd5, 1'b1, 1'b0);
        chk("tp1b_dat", 32'(u_out_data), 32'd3);
        step("tp1c", 1'b1, 8'd4, 1'b0, 8'd0, 8'd5, 1'b1, 1'b0);
        chk("tp1c_dat", 32'(u_out_data), 32'd5);
        chk("tp1c_sat", 32'(u_out_sat), 32'd1);
        chk("tp1c_cnt", 32'(u_cnt), 32'd1);
        chk("tp1c_stk", 32'(u_sticky), 32'd1);

        // Signed window [-4,3] starting from a cleared accumulator.
        step("tp2a", 1'b1, 8'hFD, 1'b1, 8'hFC, 8'h03, 1'b1, 1'b0);
        chk("tp2a_dat", 32'(s_out_data), 32'hFD);
        step("tp2b", 1'b1, 8'hFD, 1'b0, 8'hFC, 8'h03, 1'b1, 1'b0);
        chk("tp2b_dat", 32'(s_out_data), 32'hFC);
        chk("tp2b_sat", 32'(s_out_sat), 32'd1);
        step("tp2c", 1'b1, 8'h02, 1'b0, 8'hFC, 8'h03, 1'b1, 1'b0);
        chk("tp2c_dat", 32'(s_out_data), 32'hFE);
        chk("tp2c_sat", 32'(s_out_sat), 32'd0);

        // Back-pressure: held result must stay put while the input is refused.
        step("tp3a", 1'b1, 8'd7, 1'b1, 8'd0, 8'd200, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("tp3s", 1'b1, 8'd7, 1'b0, 8'd0, 8'd200, 1'b0, 1'b0);
            chk("tp3s_dat", 32'(u_out_data), 32'd7);
        end
        step("tp3r", 1'b1, 8'd7, 1'b0, 8'd0, 8'd200, 1'b1, 1'b0);
        chk("tp3r_dat", 32'(u_out_data), 32'd14);
        step("tp3e", 1'b0, 8'd0, 1'b0, 8'd0, 8'd200, 1'b1, 1'b0);

        // Clear with and without an accepted sample.
        step("tp4a", 1'b1, 8'd3, 1'b1, 8'd0, 8'd100, 1'b1, 1'b0);
        step("tp4b", 1'b1, 8'd2, 1'b1, 8'd0, 8'd100, 1'b1, 1'b0);
        chk("tp4b_dat", 32'(u_out_data), 32'd2);
        step("tp4c", 1'b0, 8'd9, 1'b1, 8'd0, 8'd100, 1'b1, 1'b0);
        chk("tp4c_vld", 32'(u_out_valid), 32'd0);
        step("tp4d", 1'b1, 8'd1, 1'b0, 8'd0, 8'd100, 1'b1, 1'b0);
        chk("tp4d_dat", 32'(s_out_data), 32'd1);

        // Asynchronous reset while a result is stalled.
        step("tp6a", 1'b1, 8'd9, 1'b0, 8'd0, 8'd100, 1'b0, 1'b0);
        step("tp6b", 1'b0, 8'd0, 1'b0, 8'd0, 8'd100, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("tp6_u_vld", 32'(u_out_valid), 32'd0);
        chk("tp6_u_dat", 32'(u_out_data), 32'd0);
        chk("tp6_s_dat", 32'(s_out_data), 32'd0);
        chk("tp6_u_cnt", 32'(u_cnt), 32'd0);
        chk("tp6_u_stk", 32'(u_sticky), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step("tp6c", 1'b1, 8'd4, 1'b0, 8'd0, 8'd200, 1'b1, 1'b0);
        chk("tp6c_dat", 32'(u_out_data), 32'd4);

        // Saturation counter on the CNT_W=2 instance stops at 3.
        step("tp5z", 1'b0, 8'd0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step("tp5", 1'b1, 8'd1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0);
            chk("tp5_cnt", 32'(u_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        step("tp5c", 1'b0, 8'd0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1);
        chk("tp5c_stk", 32'(u_sticky), 32'd0);

        // Random traffic, mostly narrow windows so clamping is frequent.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] lo;
            logic [7:0] hi;
            lo = 8'($urandom);
            hi = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                lo = 8'($urandom_range(0, 40)) - 8'd20;
                hi = lo + 8'($urandom_range(0, 60));
            end
            step("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 30)) - 8'd12,
                 1'($urandom_range(0, 9) == 0), lo, hi,
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
